// File: rtl/complex_nr_mult_pipe.sv
// Pipelined signed complex multiplier; 3-stage pipe into an output FIFO, result visible 3 edges after acceptance.
// Credit admission keeps the never-stalling pipe from overrunning the FIFO; COMPLEX_MULT_CONJ_EN adds op_conj (op_1*conj(op_2)).
module complex_nr_mult_pipe #(
  parameter int  DATA_WIDTH = 8,
  parameter int  FIFO_DEPTH = 8,
  localparam int RES_WIDTH  = 2*DATA_WIDTH+1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         sw_rst,
  input  logic                         op_val,
  output logic                         op_ready,
  input  logic signed [DATA_WIDTH-1:0] op_1_re,
  input  logic signed [DATA_WIDTH-1:0] op_1_im,
  input  logic signed [DATA_WIDTH-1:0] op_2_re,
  input  logic signed [DATA_WIDTH-1:0] op_2_im,
`ifdef COMPLEX_MULT_CONJ_EN
  input  logic                         op_conj,
`endif
  output logic                         res_val,
  input  logic                         res_ready,
  output logic signed [RES_WIDTH-1:0]  result_re,
  output logic signed [RES_WIDTH-1:0]  result_im
);

  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int SUM_W  = PW + 2;
  localparam int PROD_W = 2*DATA_WIDTH;

  // Stage 1: operand registers
  logic                         r_s1_vld;
  logic signed [DATA_WIDTH-1:0] r_s1_a, r_s1_b, r_s1_c, r_s1_d;
  logic                         r_s1_conj;

  // Stage 2: partial products
  logic                         r_s2_vld;
  logic signed [PROD_W-1:0]     r_s2_ac, r_s2_bd, r_s2_ad, r_s2_bc;
  logic                         r_s2_conj;

  // Stage 3: combined result
  logic                         r_s3_vld;
  logic signed [RES_WIDTH-1:0]  r_s3_re, r_s3_im;

  // Output FIFO
  logic signed [RES_WIDTH-1:0]  r_mem_re [FIFO_DEPTH];
  logic signed [RES_WIDTH-1:0]  r_mem_im [FIFO_DEPTH];
  logic [PW-1:0]                r_wr_ptr, r_rd_ptr;
  logic [PW:0]                  r_count;

  logic                         w_in_fire;
  logic                         w_conj_in;
  logic                         w_fifo_wr;
  logic                         w_fifo_rd;
  logic [SUM_W-1:0]             w_used;
  logic signed [PROD_W-1:0]     w_a_x, w_b_x, w_c_x, w_d_x;
  logic signed [RES_WIDTH-1:0]  w_ac_x, w_bd_x, w_ad_x, w_bc_x;
  logic signed [RES_WIDTH-1:0]  w_re, w_im;

`ifdef COMPLEX_MULT_CONJ_EN
  assign w_conj_in = op_conj;
`else
  assign w_conj_in = 1'b0;
`endif

  // Credit counts every result that will land in the FIFO; a same-cycle pop is ignored.
  assign w_used   = SUM_W'(r_count) + SUM_W'(r_s1_vld) + SUM_W'(r_s2_vld) + SUM_W'(r_s3_vld);
  assign op_ready = !sw_rst && (w_used < SUM_W'(FIFO_DEPTH));
  assign w_in_fire = op_val && op_ready;

  assign res_val   = (r_count != '0);
  assign result_re = r_mem_re[r_rd_ptr];
  assign result_im = r_mem_im[r_rd_ptr];

  assign w_fifo_wr = r_s3_vld;
  assign w_fifo_rd = res_val && res_ready;

  // Operands sign-extended to product width so each multiply is exact.
  assign w_a_x = {{DATA_WIDTH{r_s1_a[DATA_WIDTH-1]}}, r_s1_a};
  assign w_b_x = {{DATA_WIDTH{r_s1_b[DATA_WIDTH-1]}}, r_s1_b};
  assign w_c_x = {{DATA_WIDTH{r_s1_c[DATA_WIDTH-1]}}, r_s1_c};
  assign w_d_x = {{DATA_WIDTH{r_s1_d[DATA_WIDTH-1]}}, r_s1_d};

  assign w_ac_x = {r_s2_ac[PROD_W-1], r_s2_ac};
  assign w_bd_x = {r_s2_bd[PROD_W-1], r_s2_bd};
  assign w_ad_x = {r_s2_ad[PROD_W-1], r_s2_ad};
  assign w_bc_x = {r_s2_bc[PROD_W-1], r_s2_bc};

  always_comb begin
    w_re = w_ac_x - w_bd_x;
    w_im = w_ad_x + w_bc_x;
    if (r_s2_conj) begin
      w_re = w_ac_x + w_bd_x;
      w_im = w_bc_x - w_ad_x;
    end
  end

  // Control: valids, pointers and count; soft reset has priority over any transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s3_vld <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (sw_rst) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s3_vld <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_s1_vld <= w_in_fire;
      r_s2_vld <= r_s1_vld;
      r_s3_vld <= r_s2_vld;
      if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_fifo_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_fifo_wr, w_fifo_rd})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s1_c    <= '0;
      r_s1_d    <= '0;
      r_s1_conj <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_a    <= op_1_re;
      r_s1_b    <= op_1_im;
      r_s1_c    <= op_2_re;
      r_s1_d    <= op_2_im;
      r_s1_conj <= w_conj_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s2_ac   <= '0;
      r_s2_bd   <= '0;
      r_s2_ad   <= '0;
      r_s2_bc   <= '0;
      r_s2_conj <= 1'b0;
    end else if (r_s1_vld) begin
      r_s2_ac   <= w_a_x * w_c_x;
      r_s2_bd   <= w_b_x * w_d_x;
      r_s2_ad   <= w_a_x * w_d_x;
      r_s2_bc   <= w_b_x * w_c_x;
      r_s2_conj <= r_s1_conj;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s3_re <= '0;
      r_s3_im <= '0;
    end else if (r_s2_vld) begin
      r_s3_re <= w_re;
      r_s3_im <= w_im;
    end
  end

  // Entries are cleared on hard reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_re[i] <= '0;
        r_mem_im[i] <= '0;
      end
    end else if (w_fifo_wr && !sw_rst) begin
      r_mem_re[r_wr_ptr] <= r_s3_re;
      r_mem_im[r_wr_ptr] <= r_s3_im;
    end
  end

endmodule

// File: tb/tb_complex_nr_mult_pipe.sv
// Directed bench for complex_nr_mult_pipe: latency, corners, backpressure, streaming, soft/hard reset, conj.
module tb_complex_nr_mult_pipe;
  localparam int DW = 8;
  localparam int FD = 8;
  localparam int RW = 2*DW+1;

  logic                 clk = 1'b0;
  logic                 rstn, sw_rst, op_val, res_ready, op_conj;
  logic                 op_ready, res_val;
  logic signed [DW-1:0] op_1_re, op_1_im, op_2_re, op_2_im;
  logic signed [RW-1:0] result_re, result_im;

  int     checks   = 0;
  int     failures = 0;
  int     n_acc    = 0;
  int     n_pop    = 0;
  int     ovf      = 0;
  longint q_re[$];
  longint q_im[$];

  always #5 clk = ~clk;

  complex_nr_mult_pipe #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sw_rst    (sw_rst),
    .op_val    (op_val),
    .op_ready  (op_ready),
    .op_1_re   (op_1_re),
    .op_1_im   (op_1_im),
    .op_2_re   (op_2_re),
    .op_2_im   (op_2_im),
`ifdef COMPLEX_MULT_CONJ_EN
    .op_conj   (op_conj),
`endif
    .res_val   (res_val),
    .res_ready (res_ready),
    .result_re (result_re),
    .result_im (result_im)
  );

  // A FIFO write while the FIFO is already full must never happen.
  always @(posedge clk)
    if (rstn && !sw_rst && dut.r_s3_vld && (dut.r_count == FD)) ovf <= ovf + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ops(input int a, input int b, input int c, input int d);
    op_1_re = DW'(a);
    op_1_im = DW'(b);
    op_2_re = DW'(c);
    op_2_im = DW'(d);
  endtask

  task automatic set_bp(input int k);
    set_ops(k + 1, -(k + 2), 3*k - 7, 11 - 2*k);
  endtask

  function automatic void model(input longint a, input longint b, input longint c,
                                input longint d, input logic cj,
                                output longint re, output longint im);
    if (cj) begin
      re = a*c + b*d;
      im = b*c - a*d;
    end else begin
      re = a*c - b*d;
      im = a*d + b*c;
    end
  endfunction

  // Records the transfers that the coming edge will perform, then advances one cycle.
  task automatic step();
    longint er, ei;
    logic   cj;
    cj = 1'b0;
`ifdef COMPLEX_MULT_CONJ_EN
    cj = op_conj;
`endif
    if (op_val && op_ready) begin
      model(op_1_re, op_1_im, op_2_re, op_2_im, cj, er, ei);
      q_re.push_back(er);
      q_im.push_back(ei);
      n_acc++;
    end
    if (res_val && res_ready) begin
      checks++;
      assert (q_re.size() != 0) else begin
        failures++;
        $error("FAIL sb_empty: got a result, expected none pending");
      end
      if (q_re.size() != 0) begin
        er = q_re.pop_front();
        ei = q_im.pop_front();
        check("sb_re", result_re, er);
        check("sb_im", result_im, ei);
      end
      n_pop++;
    end
    tick();
  endtask

  initial begin
    rstn = 1'b0; sw_rst = 1'b0; op_val = 1'b0; res_ready = 1'b0; op_conj = 1'b0;
    set_ops(0, 0, 0, 0);
    #3;
    check("rst_op_ready", op_ready, 1);
    check("rst_res_val", res_val, 0);
    check("rst_result_re", result_re, 0);
    check("rst_result_im", result_im, 0);
    sw_rst = 1'b1;
    #1;
    check("rst_op_ready_swrst", op_ready, 0);
    sw_rst = 1'b0;
    #13 rstn = 1'b1;
    @(negedge clk);

    // Basic latency: (3+4j)(5+6j) = -9+38j
    set_ops(3, 4, 5, 6); op_val = 1'b1; res_ready = 1'b1;
    tick();
    op_val = 1'b0;
    check("lat_e0_res_val", res_val, 0);
    tick();
    check("lat_e1_res_val", res_val, 0);
    tick();
    check("lat_e2_res_val", res_val, 0);
    tick();
    check("lat_e3_res_val", res_val, 1);
    check("basic_re", result_re, -9);
    check("basic_im", result_im, 38);
    tick();
    check("basic_drained", res_val, 0);

    // Corners at full width
    set_ops(-128, -128, -128, -128); op_val = 1'b1;
    tick();
    set_ops(127, -128, -128, 127);
    tick();
    op_val = 1'b0;
    tick();
    tick();
    check("corner1_val", res_val, 1);
    check("corner1_re", result_re, 0);
    check("corner1_im", result_im, 32768);
    tick();
    check("corner2_val", res_val, 1);
    check("corner2_re", result_re, 0);
    check("corner2_im", result_im, 32513);
    tick();
    check("corner_drained", res_val, 0);

    // Backpressure: 10 offered, exactly FD accepted while the consumer stalls
    n_acc = 0; n_pop = 0; res_ready = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      set_bp(n_acc);
      op_val = (n_acc < 10);
      step();
    end
    check("bp_accepted", n_acc, 8);
    check("bp_op_ready", op_ready, 0);
    check("bp_res_val", res_val, 1);
    res_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && n_pop < 10; cyc++) begin
      set_bp(n_acc);
      op_val = (n_acc < 10);
      step();
    end
    op_val = 1'b0;
    check("bp_total_acc", n_acc, 10);
    check("bp_total_pop", n_pop, 10);
    check("bp_sb_empty", q_re.size(), 0);

    // Random streaming with random valid/ready at 70%
    n_acc = 0; n_pop = 0;
    for (int cyc = 0; cyc < 3000 && n_pop < 100; cyc++) begin
      set_ops(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
              int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
      op_val    = (n_acc < 100) && ($urandom_range(99) < 70);
      res_ready = ($urandom_range(99) < 70);
      step();
    end
    op_val = 1'b0;
    check("stream_acc", n_acc, 100);
    check("stream_pop", n_pop, 100);
    check("stream_sb_empty", q_re.size(), 0);

    // Soft reset with 3 in flight and 2 queued
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_ops(i + 1, i + 2, i + 3, i + 4); op_val = 1'b1;
      tick();
    end
    op_val = 1'b0; sw_rst = 1'b1;
    #1;
    check("srst_pre_res_val", res_val, 1);
    check("srst_op_ready_low", op_ready, 0);
    tick();
    sw_rst = 1'b0;
    #1;
    check("srst_res_val", res_val, 0);
    check("srst_op_ready", op_ready, 1);
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("srst_no_stale", res_val, 0);
    end

    // Hard reset asserted mid-cycle with work outstanding
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_ops(i + 2, -i, i - 3, 7); op_val = 1'b1;
      tick();
    end
    op_val = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("hrst_res_val", res_val, 0);
    check("hrst_op_ready", op_ready, 1);
    check("hrst_result_re", result_re, 0);
    check("hrst_result_im", result_im, 0);
    #1 rstn = 1'b1;
    @(negedge clk);
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("hrst_no_stale", res_val, 0);
    end
    set_ops(3, 4, 5, 6); op_val = 1'b1;
    tick();
    op_val = 1'b0;
    tick();
    tick();
    tick();
    check("hrst_post_val", res_val, 1);
    check("hrst_post_re", result_re, -9);
    check("hrst_post_im", result_im, 38);
    tick();

`ifdef COMPLEX_MULT_CONJ_EN
    // (3+4j)*conj(5+6j) = 39+2j, then the plain product back-to-back
    set_ops(3, 4, 5, 6); op_conj = 1'b1; op_val = 1'b1;
    tick();
    op_conj = 1'b0;
    tick();
    op_val = 1'b0;
    tick();
    tick();
    check("conj_re", result_re, 39);
    check("conj_im", result_im, 2);
    tick();
    check("plain_re", result_re, -9);
    check("plain_im", result_im, 38);
    tick();
`endif

    check("no_fifo_overflow", ovf, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
